// File: rtl/ni_packet_tx.sv
// Network-interface packet transmitter: packet request + payload stream -> header/body/tail flits on an RTS/CTS link.
// Optional feature: define NI_PARITY_EN to put even parity over the flit in bit [0].
module ni_packet_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int AXIS       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AXIS-1:0]       cur_addr,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [AXIS-1:0]       pkt_dst,
    input  logic [11:0]           pkt_len,
    input  logic                  pl_valid,
    output logic                  pl_ready,
    input  logic [27:0]           pl_data,
    output logic [DATA_WIDTH-1:0] TX,
    output logic                  RTS,
    input  logic                  DCTS,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_BODY,
        S_TAIL
    } state_t;

    state_t                  state_q, state_d;
    logic [11:0]             rem_q, rem_d;
    logic [11:0]             len_q, len_d;
    logic [AXIS-1:0]         dst_q, dst_d;
    logic [7:0]              seq_q, seq_d;
    logic                    gap_q, gap_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic                    rts_q, rts_d;

    logic                    launch;
    logic [11:0]             len_clamped;
    logic [30:0]             flit_hi;
    logic [31:0]             flit_w;

    // A flit may leave only after the idle gap cycle, so DCTS already reflects the previous write.
    always_comb begin
        launch = (state_q != S_IDLE) && !gap_q && DCTS &&
                 ((state_q == S_HDR) || pl_valid);
    end

    always_comb begin
        len_clamped = (pkt_len < 12'd2) ? 12'd2 : pkt_len;
    end

    always_comb begin
        flit_hi = {3'b010, pl_data};
        case (state_q)
            S_HDR:   flit_hi = {3'b001, len_q, 4'(dst_q), 4'(cur_addr), seq_q};
            S_TAIL:  flit_hi = {3'b100, pl_data};
            default: flit_hi = {3'b010, pl_data};
        endcase
`ifdef NI_PARITY_EN
        flit_w = {flit_hi, ^flit_hi};
`else
        flit_w = {flit_hi, 1'b0};
`endif
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        len_d   = len_q;
        dst_d   = dst_q;
        seq_d   = seq_q;
        gap_d   = launch;
        tx_d    = tx_q;
        rts_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pkt_valid) begin
                    len_d   = len_clamped;
                    dst_d   = pkt_dst;
                    rem_d   = len_clamped - 12'd2;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (launch) begin
                    state_d = (rem_q != 12'd0) ? S_BODY : S_TAIL;
                end
            end
            S_BODY: begin
                if (launch) begin
                    rem_d = rem_q - 12'd1;
                    if (rem_q == 12'd1) begin
                        state_d = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                if (launch) begin
                    state_d = S_IDLE;
                    seq_d   = seq_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            tx_d  = DATA_WIDTH'(flit_w);
            rts_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            len_q   <= '0;
            dst_q   <= '0;
            seq_q   <= '0;
            gap_q   <= 1'b0;
            tx_q    <= '0;
            rts_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            dst_q   <= dst_d;
            seq_q   <= seq_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            rts_q   <= rts_d;
        end
    end

    assign TX        = tx_q;
    assign RTS       = rts_q;
    assign pkt_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    // Payload is taken exactly on the edges where its flit can launch.
    assign pl_ready  = ((state_q == S_BODY) || (state_q == S_TAIL)) && !gap_q && DCTS;

endmodule

// File: tb/tb_ni_packet_tx.sv
// Scoreboard bench for ni_packet_tx: expected flits are queued per request, a negedge monitor checks each RTS flit.
module tb_ni_packet_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cur_addr;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [3:0]  pkt_dst;
    logic [11:0] pkt_len;
    logic        pl_valid;
    logic        pl_ready;
    logic [27:0] pl_data;
    logic [31:0] TX;
    logic        RTS;
    logic        DCTS;
    logic        busy;

    ni_packet_tx #(.DATA_WIDTH(32), .AXIS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cur_addr  (cur_addr),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_dst   (pkt_dst),
        .pkt_len   (pkt_len),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .TX        (TX),
        .RTS       (RTS),
        .DCTS      (DCTS),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [27:0] pl_q[$];
    logic [7:0]  model_seq;

    int dcts_mode;   // 0 low, 1 high, 2 random
    int plv_mode;    // 0 low, 1 valid whenever a word is queued, 2 random

    logic        s_rts, s_busy, s_pkt_ready, s_pl_ready;
    logic [31:0] s_tx;
    logic        pkt_fire, pl_fire;

    logic        prev_rts;
    logic [31:0] last_tx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkflit(input logic [2:0] id, input logic [27:0] f);
        logic [31:0] w;
        w = {id, f, 1'b0};
`ifdef NI_PARITY_EN
        w[0] = ^w[31:1];
`endif
        return w;
    endfunction

    task automatic sample();
        s_rts       = RTS;
        s_tx        = TX;
        s_busy      = busy;
        s_pkt_ready = pkt_ready;
        s_pl_ready  = pl_ready;
        pkt_fire    = pkt_valid && pkt_ready;
        pl_fire     = pl_valid && pl_ready;
    endtask

    task automatic drive();
        case (dcts_mode)
            0:       DCTS = 1'b0;
            1:       DCTS = 1'b1;
            default: DCTS = ($urandom_range(0, 9) < 7);
        endcase
        if (pl_q.size() > 0) begin
            pl_data = pl_q[0];
            case (plv_mode)
                0:       pl_valid = 1'b0;
                1:       pl_valid = 1'b1;
                default: pl_valid = ($urandom_range(0, 9) < 7);
            endcase
        end else begin
            pl_data  = 28'($urandom);
            pl_valid = 1'b0;
        end
    endtask

    // One clock: apply the handshakes that happened at the edge, re-drive, then snapshot mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pl_fire && pl_q.size() > 0) void'(pl_q.pop_front());
        if (pkt_fire) pkt_valid = 1'b0;
        drive();
        #5;
        sample();
    endtask

    task automatic issue(input logic [3:0] dst, input logic [11:0] len, input bit ramp);
        int          l;
        int          n;
        logic [27:0] w;
        l = (len < 12'd2) ? 2 : int'(len);
        exp_q.push_back(mkflit(3'b001, {12'(l), dst, cur_addr, model_seq}));
        for (int i = 0; i < l - 1; i++) begin
            w = ramp ? 28'(i + 1) : 28'($urandom);
            pl_q.push_back(w);
            exp_q.push_back(mkflit((i == l - 2) ? 3'b100 : 3'b010, w));
        end
        model_seq = model_seq + 8'd1;
        pkt_dst   = dst;
        pkt_len   = len;
        pkt_valid = 1'b1;
        sample();
        n = 0;
        while (pkt_valid && n < 2000) begin
            tick();
            n++;
        end
        if (pkt_valid) begin
            chk("request_accept_timeout", 32'(pkt_valid), 32'd0);
            pkt_valid = 1'b0;
        end
    endtask

    task automatic wait_rts(input int n, input string name);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 400) begin
            tick();
            cyc++;
            if (s_rts) seen++;
        end
        chk(name, 32'(seen), 32'(n));
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while ((s_busy || exp_q.size() != 0) && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk(name, {31'd0, s_busy}, 32'd0);
    endtask

    // Monitor: every RTS pulse must carry the next expected flit; TX must hold between pulses.
    always @(negedge clk) begin
        if (!reset) begin
            prev_rts = 1'b0;
            last_tx  = TX;
        end else begin
            if (RTS) begin
                chk("rts_back_to_back", {31'd0, prev_rts}, 32'd0);
                chk("flit_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) chk("flit", TX, exp_q.pop_front());
`ifdef NI_PARITY_EN
                chk("flit_parity", {31'd0, ^TX}, 32'd0);
`endif
            end else begin
                chk("tx_hold", TX, last_tx);
            end
            prev_rts = RTS;
            last_tx  = TX;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  pat;
        logic [31:0] hdr;
        int          len;

        reset     = 1'b0;
        cur_addr  = 4'h3;
        pkt_valid = 1'b0;
        pkt_dst   = 4'h0;
        pkt_len   = 12'd0;
        pl_valid  = 1'b0;
        pl_data   = 28'd0;
        DCTS      = 1'b1;
        dcts_mode = 1;
        plv_mode  = 1;
        model_seq = 8'd0;
        prev_rts  = 1'b0;
        last_tx   = 32'd0;
        #6;
        sample();
        repeat (3) tick();

        // Reset values
        chk("reset_tx", s_tx, 32'd0);
        chk("reset_rts", {31'd0, s_rts}, 32'd0);
        chk("reset_pkt_ready", {31'd0, s_pkt_ready}, 32'd1);
        chk("reset_pl_ready", {31'd0, s_pl_ready}, 32'd0);
        chk("reset_busy", {31'd0, s_busy}, 32'd0);
        reset = 1'b1;
        tick();

        // Basic packet: header one edge after accept, then one RTS every other cycle
        issue(4'h1, 12'd4, 1'b1);
        chk("basic_rts_at_accept", {31'd0, s_rts}, 32'd0);
        chk("basic_busy", {31'd0, s_busy}, 32'd1);
        chk("basic_pkt_ready_low", {31'd0, s_pkt_ready}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            pat[i] = s_rts;
        end
        chk("basic_rts_pattern", {25'd0, pat}, 32'h55);
        chk("basic_ready_after_tail", {31'd0, s_pkt_ready}, 32'd1);
        wait_idle("basic_idle");

        // Clamp: length 0 becomes a two-flit packet using one payload word
        issue(4'h7, 12'd0, 1'b0);
        wait_rts(2, "clamp_flits");
        chk("clamp_busy_after_tail", {31'd0, s_busy}, 32'd0);
        chk("clamp_words_left", 32'(pl_q.size()), 32'd0);
        wait_idle("clamp_idle");

        // Backpressure after the header
        issue(4'h2, 12'd3, 1'b0);
        wait_rts(1, "bp_header");
        hdr = s_tx;
        dcts_mode = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rts", {31'd0, s_rts}, 32'd0);
            chk("bp_pl_ready", {31'd0, s_pl_ready}, 32'd0);
            chk("bp_tx_stable", s_tx, hdr);
        end
        dcts_mode = 1;
        tick();
        tick();
        chk("bp_resume", {31'd0, s_rts}, 32'd1);
        wait_rts(1, "bp_tail");
        wait_idle("bp_idle");

        // Payload underflow mid-packet
        issue(4'h5, 12'd5, 1'b0);
        wait_rts(2, "uf_first");
        plv_mode = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("uf_rts", {31'd0, s_rts}, 32'd0);
        end
        chk("uf_words_left", 32'(pl_q.size()), 32'd3);
        plv_mode = 1;
        wait_rts(3, "uf_rest");
        repeat (4) tick();
        wait_idle("uf_idle");

        // Asynchronous reset mid-body
        issue(4'h9, 12'd8, 1'b0);
        wait_rts(3, "ar_partial");
        reset = 1'b0;
        #2;
        chk("ar_rts", {31'd0, RTS}, 32'd0);
        chk("ar_tx", TX, 32'd0);
        chk("ar_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        exp_q.delete();
        pl_q.delete();
        model_seq = 8'd0;
        sample();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("ar_ready_after_release", {31'd0, s_pkt_ready}, 32'd1);
        chk("ar_busy_after_release", {31'd0, s_busy}, 32'd0);

        // Randomized traffic, enough packets to wrap the sequence number
        dcts_mode = 2;
        plv_mode  = 2;
        for (int p = 0; p < 300; p++) begin
            repeat ($urandom_range(0, 2)) tick();
            len = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 7) : $urandom_range(8, 30);
            issue(4'($urandom), 12'(len), 1'b0);
        end
        wait_idle("random_idle");
        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("final_payload_empty", 32'(pl_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ni_packet_tx.md
# ni_packet_tx

Network-interface packet transmitter. It takes packet requests and a payload word stream from a processing element and serialises them into header, body and tail flits. The flits drive a router's local input port (`L_RX` / `L_DRTS`) and follow that port's `L_CTS` flow control. The block is the sending end of the router's RTS/CTS flit link, with one flit per RTS pulse.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: flit width. The flit field layout below holds only for 32.
- `AXIS`, default 4: address width.

Ports:
- `clk`, input, 1: clock. All logic is rising-edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `cur_addr`, input, `AXIS`: this node's address, inserted as the source address. Static after reset.
- `pkt_valid`, input, 1: packet request valid.
- `pkt_ready`, output, 1: request accepted when high together with `pkt_valid`.
- `pkt_dst`, input, `AXIS`: destination address.
- `pkt_len`, input, 12: total flits in the packet, including the header.
- `pl_valid`, input, 1: payload word valid.
- `pl_ready`, output, 1: payload word consumed when high together with `pl_valid`.
- `pl_data`, input, 28: payload word.
- `TX`, output, `DATA_WIDTH`: flit to the router.
- `RTS`, output, 1: one-cycle request-to-send pulse per flit.
- `DCTS`, input, 1: clear-to-send from the router's input FIFO.
- `busy`, output, 1: packet in progress (state is not IDLE).

## Operation
- Flit fields:
  - [31:29] flit id: header 3'b001, body 3'b010, tail 3'b100.
  - [0] parity, or 0 when parity is compiled out (see Configuration).
- Header fields:
  - [28:17] length.
  - [16:13] dst.
  - [12:9] src (`cur_addr`).
  - [8:1] packet sequence number.
- Body and tail fields: [28:1] `pl_data`.
- Length handling:
  - A packet of length L consists of 1 header, L-2 body flits and 1 tail flit, using L-1 payload words.
  - A `pkt_len` of 0 or 1 is clamped to 2; the length field then carries 2.
- State machine: IDLE, HDR, BODY, TAIL.
  - IDLE: `pkt_ready`=1. On accept, latch dst and length, load `rem` = L-2 into a 12-bit register, and go to HDR.
  - HDR: at launch, go to BODY if `rem`≠0, otherwise go to TAIL.
  - BODY: each launch decrements `rem`; when `rem` reaches 0, go to TAIL.
  - TAIL: at launch, go to IDLE and increment the sequence number. The sequence number is 8 bits and wraps 255→0.
- Launch condition: state≠IDLE, `gap`=0, `DCTS`=1, and, for BODY or TAIL, `pl_valid`=1.
  - On a launch edge, `TX` is loaded with the flit and `RTS`←1.
  - On every other edge, `RTS`←0 and `TX` holds its value.
- `gap` register:
  - Set on each launch and cleared on the following edge.
  - This forces at least one `RTS`-low cycle between flits, so `DCTS` reflects the previous write before the next launch.
- `pl_ready` is combinational: (state ∈ {BODY, TAIL}) ∧ ¬`gap` ∧ `DCTS`. A word is consumed only on an edge where its flit is launched.
- Stalls:
  - `DCTS` low or `pl_valid` low stalls the FSM indefinitely, with no timeout.
  - A stall is not an error, and the header is never re-sent.
- Reset asserted mid-packet: the partial packet is abandoned immediately. The router-side cleanup of the truncated packet is out of scope.

## Timing
- Reset values: `TX`=0, `RTS`=0, `pkt_ready`=1, `pl_ready`=0, `busy`=0, sequence number 0, state IDLE.
- Latency:
  - Request accepted at edge k with `DCTS`=1 → header launched at edge k+1, so `RTS`=1 during cycle k+1..k+2.
  - Launch spacing is at most one flit per 2 cycles.
  - Best-case packet duration: 2L-1 cycles from the header `RTS` to the tail `RTS`, inclusive.
- `pkt_ready` is low from the accept edge through the tail launch edge. The next request can be accepted in the cycle after the tail `RTS`.
- `DCTS` is sampled only at the launch decision. A drop of `DCTS` during the `RTS`-high cycle does not cancel that flit.

## Configuration
- `NI_PARITY_EN` defined: [0] = XOR of flit bits [31:1], giving even parity over all 32 bits.
- `NI_PARITY_EN` undefined: [0] = 0. All other behaviour is identical.

## Test plan
- Basic packet: `cur_addr`=4'h3, `DCTS`=1, request dst 4'h1, len 4, payload words 28'h0000001, 28'h0000002, 28'h0000003 always valid.
  - `TX` = header {3'b001, 12'd4, 4'h1, 4'h3, 8'h00, p}, then 2 body flits, then a tail flit carrying 28'h0000003.
  - `RTS` pulses on alternate cycles, 4 pulses total.
- Clamp: request len 0 → header length field 2, 1 payload word consumed, tail sent, `busy` drops after the tail.
- Backpressure: hold `DCTS`=0 for 5 cycles after the header.
  - No `RTS`, `pl_ready`=0, `TX` stable throughout.
  - The body flit launches on the first edge after `DCTS`=1.
- Payload underflow: `pl_valid`=0 mid-packet for 3 cycles → FSM holds, `rem` unchanged, no duplicate flit.
- Sequence wrap: 257 packets of len 2 → sequence fields run 0..255 then 0; with `NI_PARITY_EN` defined, every flit's XOR over [31:0] is 0.
- Async reset mid-BODY: `reset` low between edges → `RTS`/`TX` read 0 before the next edge; `pkt_ready`=1 after release.
